ddr_rd_port_arb: RTL and testbench

- Shares one DDR read engine between the two uplink read-port controllers (port0/port1 rd_flag / rd_queue / rd_byte channels).
- Round-robin arbitration. A grant is held for a whole queue read session, from request until the read engine signals queue finish.
- Sits between the per-port read controllers and the single DDR AXI read master, so that only one port drives read-byte requests at a time.

---
 rtl/ddr_rd_port_arb.sv | 171 +++++++++++++++++
 tb/tb_ddr_rd_port_arb.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_rd_port_arb.sv
// ddr_rd_port_arb: round-robin sharing of one DDR read engine between two read ports.
// Define RD_ARB_TIMEOUT_EN to force-release a grant after P_TIMEOUT idle cycles.

module ddr_rd_arb_lane #(
  parameter int P_CNT_WIDTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_grant,
  input  logic                   i_end,
  input  logic                   i_done,
  input  logic                   i_ddr_ready,
  output logic                   o_ready,
  output logic                   o_finish,
  output logic [P_CNT_WIDTH-1:0] o_cnt
);

  assign o_ready = i_ddr_ready & i_grant;

  // i_end covers finish and forced release; only a real finish counts a session
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_finish <= 1'b0;
      o_cnt    <= '0;
    end else begin
      o_finish <= i_grant & i_end;
      if (i_grant & i_done) o_cnt <= o_cnt + P_CNT_WIDTH'(1);
    end
  end

endmodule

module ddr_rd_port_arb #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int P_DDR_LOCAL_QUEUE  = 4,
  parameter int P_CNT_WIDTH        = 16,
  parameter int P_TIMEOUT          = 1024
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_port0_rd_flag,
  input  logic [P_DDR_LOCAL_QUEUE-1:0]  i_port0_rd_queue,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] i_port0_rd_byte,
  input  logic                          i_port0_rd_byte_valid,
  output logic                          o_port0_rd_byte_ready,
  output logic                          o_port0_rd_queue_finish,
  output logic                          o_port0_grant,
  input  logic                          i_port1_rd_flag,
  input  logic [P_DDR_LOCAL_QUEUE-1:0]  i_port1_rd_queue,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] i_port1_rd_byte,
  input  logic                          i_port1_rd_byte_valid,
  output logic                          o_port1_rd_byte_ready,
  output logic                          o_port1_rd_queue_finish,
  output logic                          o_port1_grant,
  output logic                          o_ddr_rd_flag,
  output logic [P_DDR_LOCAL_QUEUE-1:0]  o_ddr_rd_queue,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] o_ddr_rd_byte,
  output logic                          o_ddr_rd_byte_valid,
  input  logic                          i_ddr_rd_byte_ready,
  input  logic                          i_ddr_rd_queue_finish,
  output logic [P_CNT_WIDTH-1:0]        o_port0_grant_cnt,
  output logic [P_CNT_WIDTH-1:0]        o_port1_grant_cnt,
  output logic                          o_timeout
);

  localparam int NUM_PORTS = 2;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_REL   = 2'd2;

  logic [1:0]                   state;
  logic                         sel, last, pick, in_grant;
  logic                         sess_done, sess_end;
  logic [P_DDR_LOCAL_QUEUE-1:0] q_lat;

  logic [NUM_PORTS-1:0]                         req, port_v, lane_gnt, lane_rdy, lane_fin;
  logic [NUM_PORTS-1:0][P_DDR_LOCAL_QUEUE-1:0]  port_q;
  logic [NUM_PORTS-1:0][C_M_AXI_ADDR_WIDTH-1:0] port_b;
  logic [NUM_PORTS-1:0][P_CNT_WIDTH-1:0]        lane_cnt;

  assign req    = {i_port1_rd_flag, i_port0_rd_flag};
  assign port_v = {i_port1_rd_byte_valid, i_port0_rd_byte_valid};
  assign port_q = {i_port1_rd_queue, i_port0_rd_queue};
  assign port_b = {i_port1_rd_byte, i_port0_rd_byte};

  assign in_grant  = (state == S_GRANT);
  // on contention favour the port that did not own the previous session
  assign pick      = (&req) ? ~last : req[1];
  assign sess_done = in_grant & i_ddr_rd_queue_finish;

`ifdef RD_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(P_TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             hs, tmo_hit;

  assign hs      = in_grant & port_v[sel] & i_ddr_rd_byte_ready;
  assign tmo_hit = in_grant & ~i_ddr_rd_queue_finish & ~hs & (tmo_cnt == TMO_W'(P_TIMEOUT - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tmo_cnt   <= '0;
      o_timeout <= 1'b0;
    end else begin
      o_timeout <= tmo_hit;
      if (!in_grant || hs) tmo_cnt <= '0;
      else                 tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  assign sess_end = sess_done | tmo_hit;
`else
  assign o_timeout = 1'b0;
  assign sess_end  = sess_done;
`endif

  // RELEASE is the bubble after a session; it may arbitrate so the next grant
  // lands two cycles after the finish cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
      sel   <= 1'b0;
      last  <= 1'b1;
      q_lat <= '0;
    end else begin
      case (state)
        S_GRANT: if (sess_end) begin
          state <= S_REL;
          last  <= sel;
        end
        S_IDLE, S_REL: if (|req) begin
          state <= S_GRANT;
          sel   <= pick;
          q_lat <= port_q[pick];
        end else begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_lane
    assign lane_gnt[g] = in_grant & (sel == 1'(g));
    ddr_rd_arb_lane #(.P_CNT_WIDTH(P_CNT_WIDTH)) u_lane (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_grant     (lane_gnt[g]),
      .i_end       (sess_end),
      .i_done      (sess_done),
      .i_ddr_ready (i_ddr_rd_byte_ready),
      .o_ready     (lane_rdy[g]),
      .o_finish    (lane_fin[g]),
      .o_cnt       (lane_cnt[g])
    );
  end

  assign o_ddr_rd_flag       = in_grant;
  assign o_ddr_rd_queue      = in_grant ? q_lat : '0;
  assign o_ddr_rd_byte       = in_grant ? port_b[sel] : '0;
  assign o_ddr_rd_byte_valid = in_grant & port_v[sel];

  assign o_port0_grant           = lane_gnt[0];
  assign o_port1_grant           = lane_gnt[1];
  assign o_port0_rd_byte_ready   = lane_rdy[0];
  assign o_port1_rd_byte_ready   = lane_rdy[1];
  assign o_port0_rd_queue_finish = lane_fin[0];
  assign o_port1_rd_queue_finish = lane_fin[1];
  assign o_port0_grant_cnt       = lane_cnt[0];
  assign o_port1_grant_cnt       = lane_cnt[1];

endmodule

// File: tb/tb_ddr_rd_port_arb.sv
// Self-checking bench for ddr_rd_port_arb: directed scenarios plus random traffic vs a session-level model.
module tb_ddr_rd_port_arb;
  localparam int AW = 32, QW = 4, CW = 16, TMO = 16;

  logic clk = 1'b0, rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          p0_flag, p1_flag, p0_v, p1_v, ddr_rdy, ddr_fin;
  logic [QW-1:0] p0_q, p1_q;
  logic [AW-1:0] p0_b, p1_b;

  logic          o_port0_rd_byte_ready, o_port0_rd_queue_finish, o_port0_grant;
  logic          o_port1_rd_byte_ready, o_port1_rd_queue_finish, o_port1_grant;
  logic          o_ddr_rd_flag, o_ddr_rd_byte_valid, o_timeout;
  logic [QW-1:0] o_ddr_rd_queue;
  logic [AW-1:0] o_ddr_rd_byte;
  logic [CW-1:0] o_port0_grant_cnt, o_port1_grant_cnt;

  ddr_rd_port_arb #(.C_M_AXI_ADDR_WIDTH(AW), .P_DDR_LOCAL_QUEUE(QW), .P_CNT_WIDTH(CW), .P_TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_port0_rd_flag(p0_flag), .i_port0_rd_queue(p0_q), .i_port0_rd_byte(p0_b), .i_port0_rd_byte_valid(p0_v),
    .o_port0_rd_byte_ready(o_port0_rd_byte_ready), .o_port0_rd_queue_finish(o_port0_rd_queue_finish),
    .o_port0_grant(o_port0_grant),
    .i_port1_rd_flag(p1_flag), .i_port1_rd_queue(p1_q), .i_port1_rd_byte(p1_b), .i_port1_rd_byte_valid(p1_v),
    .o_port1_rd_byte_ready(o_port1_rd_byte_ready), .o_port1_rd_queue_finish(o_port1_rd_queue_finish),
    .o_port1_grant(o_port1_grant),
    .o_ddr_rd_flag(o_ddr_rd_flag), .o_ddr_rd_queue(o_ddr_rd_queue), .o_ddr_rd_byte(o_ddr_rd_byte),
    .o_ddr_rd_byte_valid(o_ddr_rd_byte_valid), .i_ddr_rd_byte_ready(ddr_rdy), .i_ddr_rd_queue_finish(ddr_fin),
    .o_port0_grant_cnt(o_port0_grant_cnt), .o_port1_grant_cnt(o_port1_grant_cnt), .o_timeout(o_timeout)
  );

  int checks = 0, failures = 0;

  // session-level reference: who owns the engine, who is preferred next, counts
  int            m_owner, m_prefer, m_idle;
  int            m_cnt [2];
  logic [QW-1:0] m_q;
  logic [1:0]    m_fin;
  logic          m_tmo;

  task automatic model_reset();
    m_owner = -1; m_prefer = 0; m_idle = 0;
    m_cnt[0] = 0; m_cnt[1] = 0;
    m_q = '0; m_fin = 2'b00; m_tmo = 1'b0;
  endtask

  task automatic model_step();
    logic tmo;
`ifdef RD_ARB_TIMEOUT_EN
    logic hs;
`endif
    tmo = 1'b0;
    m_fin = 2'b00;
    if (m_owner >= 0) begin
`ifdef RD_ARB_TIMEOUT_EN
      hs = ddr_rdy && (m_owner == 0 ? p0_v : p1_v);
      m_idle = hs ? 0 : m_idle + 1;
      tmo = !ddr_fin && (m_idle >= TMO);
`endif
      if (ddr_fin || tmo) begin
        m_fin[m_owner] = 1'b1;
        if (ddr_fin) m_cnt[m_owner] = (m_cnt[m_owner] + 1) % 65536;
        m_prefer = 1 - m_owner;
        m_owner = -1;
      end
    end else if (p0_flag || p1_flag) begin
      m_owner = (p0_flag && p1_flag) ? m_prefer : (p1_flag ? 1 : 0);
      m_q = (m_owner == 1) ? p1_q : p0_q;
      m_idle = 0;
    end
    m_tmo = tmo;
  endtask

  function automatic logic [76:0] exp_vec();
    logic g0, g1, v;
    logic [AW-1:0] b;
    g0 = (m_owner == 0);
    g1 = (m_owner == 1);
    b  = g0 ? p0_b : (g1 ? p1_b : AW'(0));
    v  = (g0 && p0_v) || (g1 && p1_v);
    return {g1, g0, g0 || g1, (g0 || g1) ? m_q : QW'(0), b, v, ddr_rdy && g1, ddr_rdy && g0,
            m_fin, m_tmo, CW'(m_cnt[1]), CW'(m_cnt[0])};
  endfunction

  function automatic logic [76:0] obs_vec();
    return {o_port1_grant, o_port0_grant, o_ddr_rd_flag, o_ddr_rd_queue, o_ddr_rd_byte, o_ddr_rd_byte_valid,
            o_port1_rd_byte_ready, o_port0_rd_byte_ready, o_port1_rd_queue_finish, o_port0_rd_queue_finish,
            o_timeout, o_port1_grant_cnt, o_port0_grant_cnt};
  endfunction

  task automatic clear_inputs();
    p0_flag = 0; p1_flag = 0; p0_v = 0; p1_v = 0; ddr_rdy = 0; ddr_fin = 0;
    p0_q = '0; p1_q = '0; p0_b = '0; p1_b = '0;
  endtask

  // tasks start and end at the drive point, 1 time unit after a rising edge
  task automatic advance();
    model_step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 0; clear_inputs(); model_reset();
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 0;
    model_reset();
    p0_flag = 1; p1_flag = 1; p0_v = 1; ddr_rdy = 1; ddr_fin = 1; p0_b = 32'hDEAD_BEEF;
    #1; checks++;
    if (obs_vec() !== 77'd0) begin failures++; $display("FAIL reset_async got=%h exp=0", obs_vec()); end
    repeat (2) @(posedge clk);
    #1; checks++;
    if (obs_vec() !== 77'd0) begin failures++; $display("FAIL reset_held got=%h exp=0", obs_vec()); end
    clear_inputs();
    #2 rst_n = 1;
    @(posedge clk); #1; checks++;
    if (obs_vec() !== 77'd0) begin failures++; $display("FAIL reset_release got=%h exp=0", obs_vec()); end
  endtask

  task automatic test_single();
    p0_flag = 1; p0_q = 4'h2; p0_b = 32'h400; p0_v = 1; ddr_rdy = 1;
    #1; checks++;
    if (o_port0_grant !== 1'b0) begin failures++; $display("FAIL single_req_cycle got=%b exp=0", o_port0_grant); end
    advance();
    #1; checks++;
    if ({o_port0_grant, o_port1_grant, o_ddr_rd_flag, o_ddr_rd_queue, o_ddr_rd_byte, o_ddr_rd_byte_valid,
         o_port0_rd_byte_ready, o_port1_rd_byte_ready} !== {3'b101, 4'h2, 32'h400, 3'b110}) begin
      failures++; $display("FAIL single_grant got=%b/%h/%h exp=1/2/400", o_port0_grant, o_ddr_rd_queue, o_ddr_rd_byte);
    end
    advance();
    p0_q = 4'h7; p0_flag = 0; ddr_fin = 1;
    #1; checks++;
    if (obs_vec() !== exp_vec()) begin failures++; $display("FAIL single_latched got=%h exp=%h", obs_vec(), exp_vec()); end
    advance();
    ddr_fin = 0;
    #1; checks++;
    if ({o_port0_rd_queue_finish, o_port0_grant, o_ddr_rd_flag, o_port0_grant_cnt} !== {3'b100, 16'd1}) begin
      failures++; $display("FAIL single_finish got=%b%b%b cnt=%0d exp=100 cnt=1",
                           o_port0_rd_queue_finish, o_port0_grant, o_ddr_rd_flag, o_port0_grant_cnt);
    end
    advance();
    #1; checks++;
    if (o_port0_rd_queue_finish !== 1'b0) begin failures++; $display("FAIL single_pulse_len got=1 exp=0"); end
    clear_inputs();
    advance();
  endtask

  task automatic test_alternate();
    do_reset();
    p0_flag = 1; p1_flag = 1; p0_b = 32'h1111; p1_b = 32'h2222; p0_v = 1; p1_v = 1; ddr_rdy = 1;
    for (int s = 0; s < 10; s++) begin
      #1; checks++;
      if ({o_port1_grant, o_port0_grant} !== 2'b00) begin failures++; $display("FAIL alt_gap s=%0d got=%b exp=00", s, {o_port1_grant, o_port0_grant}); end
      advance();
      #1; checks++;
      if ({o_port1_grant, o_port0_grant} !== ((s % 2) ? 2'b10 : 2'b01)) begin
        failures++; $display("FAIL alt_owner s=%0d got=%b exp=%b", s, {o_port1_grant, o_port0_grant}, (s % 2) ? 2'b10 : 2'b01);
      end
      advance();
      ddr_fin = 1;
      #1; checks++;
      if (obs_vec() !== exp_vec()) begin failures++; $display("FAIL alt_model s=%0d got=%h exp=%h", s, obs_vec(), exp_vec()); end
      advance();
      ddr_fin = 0;
    end
    #1; checks++;
    if ({o_port0_grant_cnt, o_port1_grant_cnt} !== {16'd5, 16'd5}) begin
      failures++; $display("FAIL alt_counts got=%0d/%0d exp=5/5", o_port0_grant_cnt, o_port1_grant_cnt);
    end
    clear_inputs();
    advance();
  endtask

  task automatic test_backpressure();
    p1_flag = 1; p1_q = 4'h9; p1_b = 32'hABCD_0123; p1_v = 1; p0_v = 1; p0_b = 32'h5555; ddr_rdy = 0;
    #1; advance();
    for (int k = 0; k < 5; k++) begin
      #1; checks++;
      if ({o_port1_grant, o_port1_rd_byte_ready, o_port0_rd_byte_ready, o_ddr_rd_byte_valid, o_ddr_rd_byte}
          !== {4'b1001, 32'hABCD_0123}) begin
        failures++; $display("FAIL bp_hold k=%0d rdy1=%b rdy0=%b byte=%h exp=0/0/abcd0123",
                             k, o_port1_rd_byte_ready, o_port0_rd_byte_ready, o_ddr_rd_byte);
      end
      advance();
    end
    ddr_rdy = 1;
    #1; checks++;
    if ({o_port1_rd_byte_ready, o_port0_rd_byte_ready} !== 2'b10) begin
      failures++; $display("FAIL bp_release got=%b exp=10", {o_port1_rd_byte_ready, o_port0_rd_byte_ready});
    end
    ddr_fin = 1; advance();
    clear_inputs();
    #1; checks++;
    if (obs_vec() !== exp_vec()) begin failures++; $display("FAIL bp_finish got=%h exp=%h", obs_vec(), exp_vec()); end
    advance();
  endtask

  task automatic test_spurious();
    ddr_fin = 1;
    for (int k = 0; k < 3; k++) begin
      #1; checks++;
      if ({o_port1_rd_queue_finish, o_port0_rd_queue_finish, o_ddr_rd_flag, o_port1_grant_cnt, o_port0_grant_cnt}
          !== {3'b000, CW'(m_cnt[1]), CW'(m_cnt[0])}) begin
        failures++; $display("FAIL spurious k=%0d fin=%b cnt=%0d/%0d exp fin=00 cnt=%0d/%0d", k,
                             {o_port1_rd_queue_finish, o_port0_rd_queue_finish}, o_port0_grant_cnt, o_port1_grant_cnt, m_cnt[0], m_cnt[1]);
      end
      advance();
    end
    ddr_fin = 0;
    #1; checks++;
    if (obs_vec() !== exp_vec()) begin failures++; $display("FAIL spurious_after got=%h exp=%h", obs_vec(), exp_vec()); end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) p0_flag = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) p1_flag = 1'($urandom_range(0, 1));
      p0_q = QW'($urandom); p1_q = QW'($urandom);
      p0_b = $urandom; p1_b = $urandom;
      p0_v = 1'($urandom_range(0, 1)); p1_v = 1'($urandom_range(0, 1));
      ddr_rdy = 1'($urandom_range(0, 1));
      ddr_fin = ($urandom_range(0, 5) == 0);
      #1; checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        if (bad < 10) $display("FAIL random c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
        bad++;
      end
      advance();
    end
    clear_inputs(); ddr_fin = 1;
    advance();
    ddr_fin = 0;
    advance();
  endtask

  task automatic test_reset_mid();
    p1_flag = 1; p1_b = 32'h77; p1_v = 1; ddr_rdy = 1;
    advance();
    #1; checks++;
    if (o_port1_grant !== 1'b1) begin failures++; $display("FAIL midreset_pre got=%b exp=1", o_port1_grant); end
    #1 rst_n = 0;
    #1; checks++;
    if (obs_vec() !== 77'd0) begin failures++; $display("FAIL midreset_outputs got=%h exp=0", obs_vec()); end
    model_reset();
    p0_flag = 1; p1_flag = 1; p0_v = 1; p0_b = 32'h88;
    @(posedge clk);
    #3 rst_n = 1;
    advance();
    checks++;
    if ({o_port1_grant, o_port0_grant, o_port1_rd_queue_finish, o_port0_rd_queue_finish} !== 4'b0100) begin
      failures++; $display("FAIL midreset_prio got=%b exp=0100",
                           {o_port1_grant, o_port0_grant, o_port1_rd_queue_finish, o_port0_rd_queue_finish});
    end
    ddr_fin = 1; advance();
    clear_inputs(); advance();
  endtask

`ifdef RD_ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    p0_flag = 1; p1_flag = 1; p0_v = 0; ddr_rdy = 1;
    advance();
    for (int k = 1; k <= TMO; k++) begin
      #1; checks++;
      if ({o_timeout, o_port0_grant} !== 2'b01) begin failures++; $display("FAIL tmo_wait k=%0d got=%b exp=01", k, {o_timeout, o_port0_grant}); end
      advance();
    end
    #1; checks++;
    if ({o_timeout, o_port0_rd_queue_finish, o_port0_grant, o_port0_grant_cnt} !== {3'b110, 16'd0}) begin
      failures++; $display("FAIL tmo_pulse got=%b%b%b cnt=%0d exp=110 cnt=0",
                           o_timeout, o_port0_rd_queue_finish, o_port0_grant, o_port0_grant_cnt);
    end
    advance();
    #1; checks++;
    if ({o_timeout, o_port1_grant} !== 2'b01) begin failures++; $display("FAIL tmo_next got=%b exp=01", {o_timeout, o_port1_grant}); end
    ddr_fin = 1; advance();
    clear_inputs(); advance();
  endtask
`endif

  initial begin
    clear_inputs();
    model_reset();
    test_reset();
    test_single();
    test_alternate();
    test_backpressure();
    test_spurious();
    test_random();
    test_reset_mid();
`ifdef RD_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
